wu_inst_fetch: RTL

WU_INST_FETCH -- requirements
Module: wu_inst_fetch

---
 rtl/wu_inst_fetch_pkg.sv | 25 ++
 rtl/wu_inst_fetch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/wu_inst_fetch_pkg.sv
// Shared WU fetch header: manager address width, FSM state encoding and the
// address-increment helper used by the WU instruction fetch unit.
package wu_inst_fetch_pkg;

    // Width of a WU instruction-memory address (manager-wide constant).
    localparam int MGR_WU_ADDRESS_WIDTH = 8;

    // Number of bits in the fetch FSM state encoding.
    localparam int WUF_STATE_WIDTH = 2;

    typedef enum logic [WUF_STATE_WIDTH-1:0] {
        WUF_IDLE  = 2'd0,
        WUF_FETCH = 2'd1,
        WUF_STALL = 2'd2,
        WUF_DONE  = 2'd3
    } wuf_state_e;

    // Next sequential WU address; wraps from all-ones back to zero.
    function automatic logic [MGR_WU_ADDRESS_WIDTH-1:0] wuf_addr_inc(
        input logic [MGR_WU_ADDRESS_WIDTH-1:0] addr
    );
        return addr + MGR_WU_ADDRESS_WIDTH'(1);
    endfunction

endpackage

// File: rtl/wu_inst_fetch.sv
// WU instruction fetch unit: walks the WU memory from a start address to a
// last address (wrapping through zero if needed), one read per cycle, pausing
// under decode backpressure and stopping early on abort.
//
// Optional feature: define MGR_WU_FETCH_STALL_CNT_EN to add the stall-cycle
// counter and its output port wuf__sys__stall_cnt.
//
// Timing model: wud__wuf__stall sampled in a cycle decides whether a read is
// presented in the following cycle. A read presented with read=1 is always a
// real read; while stalled, the address register holds the next address still
// to be fetched, so resuming never skips or repeats an address.
module wu_inst_fetch
    import wu_inst_fetch_pkg::*;
#(
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset_poweron,
    input  logic                            sys__wuf__start,
    input  logic [MGR_WU_ADDRESS_WIDTH-1:0] sys__wuf__start_addr,
    input  logic [MGR_WU_ADDRESS_WIDTH-1:0] sys__wuf__last_addr,
    input  logic                            sys__wuf__abort,
    input  logic                            wud__wuf__stall,
    output logic [MGR_WU_ADDRESS_WIDTH-1:0] wuf__wum__addr,
    output logic                            wuf__wum__read,
    output logic                            wuf__sys__busy,
    output logic                            wuf__sys__done
`ifdef MGR_WU_FETCH_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0]      wuf__sys__stall_cnt
`endif
);

    wuf_state_e                      state_reg, state_next;
    logic [MGR_WU_ADDRESS_WIDTH-1:0] addr_reg,  addr_next;
    logic [MGR_WU_ADDRESS_WIDTH-1:0] last_reg,  last_next;
    logic                            read_reg,  read_next;
    logic                            busy_reg,  busy_next;
    logic                            done_reg,  done_next;

    // Next-state and next-output decode; abort has the highest priority
    // in the active states, ahead of completion and backpressure.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        last_next  = last_reg;
        read_next  = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            WUF_IDLE: begin
                if (sys__wuf__start) begin
                    addr_next = sys__wuf__start_addr;
                    last_next = sys__wuf__last_addr;
                    if (wud__wuf__stall) begin
                        state_next = WUF_STALL;
                    end else begin
                        state_next = WUF_FETCH;
                        read_next  = 1'b1;
                    end
                end
            end
            WUF_FETCH: begin
                // A read is on the bus at addr_reg this cycle.
                if (sys__wuf__abort) begin
                    state_next = WUF_IDLE;
                end else if (addr_reg == last_reg) begin
                    state_next = WUF_DONE;
                    done_next  = 1'b1;
                end else begin
                    addr_next = wuf_addr_inc(addr_reg);
                    if (wud__wuf__stall) begin
                        state_next = WUF_STALL;
                    end else begin
                        read_next = 1'b1;
                    end
                end
            end
            WUF_STALL: begin
                // addr_reg holds the next address not yet read.
                if (sys__wuf__abort) begin
                    state_next = WUF_IDLE;
                end else if (!wud__wuf__stall) begin
                    state_next = WUF_FETCH;
                    read_next  = 1'b1;
                end
            end
            WUF_DONE: begin
                state_next = WUF_IDLE;
            end
            default: begin
                state_next = WUF_IDLE;
            end
        endcase

        busy_next = (state_next == WUF_FETCH) || (state_next == WUF_STALL);
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_reg <= WUF_IDLE;
            addr_reg  <= '0;
            last_reg  <= '0;
            read_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            last_reg  <= last_next;
            read_reg  <= read_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign wuf__wum__addr = addr_reg;
    assign wuf__wum__read = read_reg;
    assign wuf__sys__busy = busy_reg;
    assign wuf__sys__done = done_reg;

`ifdef MGR_WU_FETCH_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;
    logic                       start_accept;

    // Count cycles spent in STALL; restart on an accepted start, stick at max.
    always_comb begin
        start_accept   = (state_reg == WUF_IDLE) && sys__wuf__start;
        stall_cnt_next = stall_cnt_reg;
        if (start_accept) begin
            stall_cnt_next = '0;
        end else if ((state_reg == WUF_STALL) && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + STALL_CNT_WIDTH'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign wuf__sys__stall_cnt = stall_cnt_reg;
`endif

endmodule
